// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART subsystem: receiver state encoding,
// 3-sample majority vote and the oversampling divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Clocks per sample tick; clamped to 1 so a too-fast baud still ticks.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-clock tick every DIV clocks, restartable via clr.
// Used at OVERSAMPLE rate by the receiver and at bit rate by the transmitter.
module uart_baud_tick #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: majority vote of three mid-bit samples,
// optional parity check, framing check on the stop bit.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  rx_state_e     state, state_n;
  logic          rx_s1, rx_s2, rx_d;
  logic [SW-1:0] s;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          smp0, smp1, perr, pend;
  logic          tick, fell, start, fin, bitv;
  logic          at_lo, at_mid, at_hi, at_end;

  assign fell   = rx_d & ~rx_s2;
  // pend carries an edge that arrived while STOP was completing into IDLE.
  assign start  = (state == IDLE) && (fell || pend);
  assign at_lo  = tick && (s == S_LO);
  assign at_mid = tick && (s == S_MID);
  assign at_hi  = tick && (s == S_HI);
  assign at_end = tick && (s == S_END);
  assign bitv   = maj3(smp0, smp1, rx_s2);
  assign fin    = (state == STOP) && at_hi;
  assign busy   = (state != IDLE);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = START;
      START: begin
        if (at_hi && bitv) state_n = IDLE;
        else if (at_end)   state_n = DATA;
      end
      DATA:    if (at_end && idx == 3'd7) state_n = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (at_end) state_n = STOP;
      STOP:    if (at_hi) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      state <= state_n;
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s          <= '0;
      idx        <= '0;
      shreg      <= '0;
      smp0       <= 1'b1;
      smp1       <= 1'b1;
      perr       <= 1'b0;
      pend       <= 1'b0;
      dout       <= '0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      done <= fin;
      pend <= fin && fell;
      if (start) begin
        s   <= '0;
        idx <= '0;
      end else if (tick && state != IDLE) begin
        s <= at_end ? '0 : s + 1'b1;
      end
      if (at_lo)  smp0 <= rx_s2;
      if (at_mid) smp1 <= rx_s2;
      if (state == DATA && at_hi)  shreg <= {bitv, shreg[7:1]};
      if (state == DATA && at_end) idx <= idx + 1'b1;
      if (state == PARITY && at_hi) perr <= bitv ^ (^shreg) ^ 1'(PARITY_ODD);
      if (fin) begin
        dout       <= shreg;
        frame_err  <= ~bitv;
        parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: drivers push expected frames, monitors
// pop and compare on every done pulse. Two instances cover parity off/on.
module tb_uart_rx_os;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int BT       = 160;
  localparam int P_ODD    = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic [7:0] dout0, dout1;
  logic       done0, done1, fe0, fe1, pe0, pe1, busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;
  logic [7:0] last0 = 8'h00;

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
               .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .rx(rx0), .dout(dout0), .done(done0),
    .frame_err(fe0), .parity_err(pe0), .busy(busy0));

  uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
               .PARITY_EN(1), .PARITY_ODD(P_ODD)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .dout(dout1), .done(done1),
    .frame_err(fe1), .parity_err(pe1), .busy(busy1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done0) begin
      check("done0_width", 32'(prev0), 0);
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done0 actual=%0h expected=no_frame", dout0);
      end else begin
        e0 = q0.pop_front();
        check("dout0", 32'(dout0), 32'(e0.d));
        check("frame_err0", 32'(fe0), 32'(e0.fe));
        check("parity_err0", 32'(pe0), 32'(e0.pe));
        check("busy0_after_done", 32'(busy0), 0);
      end
    end
    prev0 = done0;
  end

  always @(negedge clk) begin
    if (done1) begin
      check("done1_width", 32'(prev1), 0);
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done1 actual=%0h expected=no_frame", dout1);
      end else begin
        e1 = q1.pop_front();
        check("dout1", 32'(dout1), 32'(e1.d));
        check("frame_err1", 32'(fe1), 32'(e1.fe));
        check("parity_err1", 32'(pe1), 32'(e1.pe));
      end
    end
    prev1 = done1;
  end

  task automatic drive_bit(input int which, input logic v, input int clks);
    if (which == 0) rx0 = v;
    else            rx1 = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  // Reference: a frame yields its byte; frame error iff stop is low; parity
  // error iff the count of ones over data+parity disagrees with the mode.
  task automatic send(input int which, input logic [7:0] d, input logic pbit, input logic stop);
    exp_t x;
    x.d  = d;
    x.fe = !stop;
    x.pe = (which == 1) ? ((($countones(d) + int'(pbit)) % 2) != P_ODD) : 1'b0;
    if (which == 0) begin q0.push_back(x); last0 = d; end
    else            q1.push_back(x);
    drive_bit(which, 1'b0, BT);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], BT);
    if (which == 1) drive_bit(which, pbit, BT);
    drive_bit(which, stop, BT);
  endtask

  initial begin
    logic [7:0] r;
    logic       st, pb;
    repeat (5) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_flags", 32'({fe0, pe0}), 0);
    check("rst_busy", 32'(busy0), 0);
    rst = 1'b1;
    drive_bit(0, 1'b1, BT);

    // Single frame, then back-to-back frames
    send(0, 8'hA5, 1'b0, 1'b1);
    send(0, 8'h00, 1'b0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1);
    send(0, 8'h3C, 1'b0, 1'b1);
    drive_bit(0, 1'b1, BT);

    // Glitch on idle line: busy rises, falls, no frame
    drive_bit(0, 1'b0, 10);
    check("glitch_busy_high", 32'(busy0), 1);
    drive_bit(0, 1'b0, 30);
    drive_bit(0, 1'b1, 2 * BT);
    check("glitch_busy_low", 32'(busy0), 0);
    check("glitch_dout_hold", 32'(dout0), 32'(last0));

    // Framing error followed by a held-low line, then a clean frame
    send(0, 8'h55, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 2 * BT);
    check("break_no_busy", 32'(busy0), 0);
    drive_bit(0, 1'b1, BT);
    send(0, 8'h12, 1'b0, 1'b1);
    drive_bit(0, 1'b1, BT);

    // Even parity: 0x07 has three ones, so parity bit 1 is correct
    send(1, 8'h07, 1'b1, 1'b1);
    send(1, 8'h07, 1'b0, 1'b1);
    drive_bit(1, 1'b1, BT);

    // Randomized frames on both instances
    for (int n = 0; n < 8; n++) begin
      r  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send(0, r, 1'b0, st);
      drive_bit(0, 1'b1, st ? $urandom_range(1, 200) : BT);
    end
    for (int n = 0; n < 4; n++) begin
      r  = 8'($urandom);
      pb = 1'($urandom);
      send(1, r, pb, 1'b1);
      drive_bit(1, 1'b1, $urandom_range(1, 100));
    end

    // Reset in DATA bit 4 of 0x81 discards the partial frame
    drive_bit(0, 1'b0, BT);
    drive_bit(0, 1'b1, BT);
    for (int i = 1; i < 4; i++) drive_bit(0, 1'b0, BT);
    drive_bit(0, 1'b0, BT / 2);
    check("midframe_busy", 32'(busy0), 1);
    rst = 1'b0;
    #2;
    check("rst2_dout", 32'(dout0), 0);
    check("rst2_outs", 32'({done0, fe0, pe0, busy0}), 0);
    last0 = 8'h00;
    drive_bit(0, 1'b0, BT / 2);
    drive_bit(0, 1'b1, 5);
    check("rst2_hold", 32'({dout0, done0, fe0, pe0, busy0}), 0);
    rst = 1'b1;
    drive_bit(0, 1'b1, BT);
    send(0, 8'h42, 1'b0, 1'b1);
    drive_bit(0, 1'b1, 3 * BT);

    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
16x-oversampled UART receiver with majority-vote bit sampling, optional parity check and framing-error detection.
- Receive-side counterpart to the existing transmitter. Tolerates glitches and baud mismatch better than the plain receiver.
- Lives beside the transmitter in the UART subsystem. Its rx pin is fed straight from the pad or the transmitter's tx line.
- Output is one byte per frame, signalled with a single-cycle done pulse plus error flags.

Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- OVERSAMPLE, 16: sample ticks per bit; must be even and ≥ 8.
- PARITY_EN, 0: 1 means a parity bit follows D7.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even; only used when PARITY_EN=1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- rx, input, 1: serial line, idle high, asynchronous to clk.
- dout, output, 8: last received byte.
- done, output, 1: one-cycle pulse when dout is updated.
- frame_err, output, 1: stop bit sampled low on the last frame.
- parity_err, output, 1: parity mismatch on the last frame.
- busy, output, 1: high from start-bit detection until the frame ends or is aborted.

Behaviour:
- Reset (rst=0, asynchronous): dout=0, done=0, frame_err=0, parity_err=0, busy=0, state=IDLE, synchronizer flops=1, tick divider=0.
- Tick divider:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation.
  - Emits a one-clk tick every DIV clocks, free-running.
  - Resynchronised to 0 on start-edge detection.
- Input conditioning: 2-flop synchronizer on rx, then a 1-flop delay for edge detection. Synchronizer latency is 2 clk.
- Sampling:
  - Each bit uses a 4-bit sample counter s, counting 0..OVERSAMPLE-1 on ticks.
  - Bit value = majority of the synchronized rx at s = OS/2-1, OS/2 and OS/2+1.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a synchronized falling edge, go to START, busy=1, s=0. A low level without an edge does not start a frame, so a break needs rx to return high first.
  - START: at s=OS/2+1, evaluate the majority.
    - Majority 1 (false start): go to IDLE, busy=0, no done.
    - Majority 0: continue counting to s=OS-1, then go to DATA with bit index 0.
  - DATA: LSB first into a shift register.
    - After bit 7 completes (s=OS-1), go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: the sampled bit is compared with the XOR of the data, inverted when PARITY_ODD=1. The result is held internally.
  - STOP: at s=OS/2+1, evaluate the majority, then in the next clk:
    - done=1.
    - dout=shift register.
    - frame_err=(stop==0).
    - parity_err=computed mismatch, or 0 when PARITY_EN=0.
    - state=IDLE, busy=0.
    - The FSM does not wait for the end of the stop bit, so back-to-back frames are accepted.
- Flag timing:
  - frame_err and parity_err update only together with done, and hold until the next done.
  - dout holds between frames, including when the frame had errors.
- done is exactly 1 clk wide and never asserts from a false start.
- A falling edge during the same cycle that STOP completes is honoured: IDLE sees the edge on the following clk.
- Reset mid-frame discards the partial frame; no done is produced.
- Frame latency: done rises OS/2+2 ticks into the stop bit, plus 2-3 clk of synchronizer and edge delay.

Decomposition:
- Package uart_pkg:
  - Typedef rx_state_e (IDLE, START, DATA, PARITY, STOP).
  - Function maj3(a,b,c).
  - Localparam helper computing DIV from the parameters.
- Sub-module uart_baud_tick: parameterised divider with clk, rst, a sync-clear input and a tick output. The transmitter can reuse it with OVERSAMPLE=1.

Test Plan:
1. CLK_FREQ=1600000, BAUD_RATE=10000 (DIV=10, 160 clk/bit), PARITY_EN=0; send 0xA5 with stop=1 → one done pulse, dout=0xA5, frame_err=0, parity_err=0, busy low after done.
2. Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap → three done pulses in order with matching dout; no frame is dropped.
3. A 40-clk low glitch on idle rx → busy pulses high then returns low; no done; dout unchanged.
4. Frame 0x55 with the stop bit driven low, then rx held low for 2 bit times, then rx high, then frame 0x12 → done with dout=0x55 and frame_err=1; no spurious frame during the low period; next done gives dout=0x12 with frame_err=0.
5. PARITY_EN=1, PARITY_ODD=0; send 0x07 with parity bit 1, then 0x07 with parity bit 0 → parity_err=0 on the first frame and 1 on the second.
6. Assert rst during DATA bit 4 of 0x81, release, send 0x42 → during reset all outputs are 0 and busy=0; no done for 0x81; the next done gives dout=0x42.
